// File: rtl/fet_check_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fet_check_pkg : shared logic-value codes, FSM states and helpers for the
//                 FET response checker.            Rev 1.0
// ---------------------------------------------------------------------------
package fet_check_pkg;

  localparam logic [1:0] LV_0 = 2'b00;
  localparam logic [1:0] LV_1 = 2'b01;
  localparam logic [1:0] LV_Z = 2'b10;
  localparam logic [1:0] LV_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  // Case equality keeps z and x distinguishable on the observed nets.
  function automatic logic [1:0] lv_encode(input logic v);
    if (v === 1'b0)      return LV_0;
    else if (v === 1'b1) return LV_1;
    else if (v === 1'bz) return LV_Z;
    else                 return LV_X;
  endfunction

  function automatic logic lv_is_driven(input logic [1:0] code);
    return (code == LV_0) || (code == LV_1);
  endfunction

endpackage : fet_check_pkg
`default_nettype wire

// File: rtl/fet_expect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fet_expect : switch-level expected terminal values for one nfet/pfet,
//              derived from the driver intent codes.      Rev 1.0
// ---------------------------------------------------------------------------
module fet_expect
  import fet_check_pkg::*;
#(
  parameter int POLARITY = 0
) (
  input  logic [1:0] i_g_drv,
  input  logic [1:0] i_a_drv,
  input  logic [1:0] i_b_drv,
  output logic [1:0] o_exp_a,
  output logic [1:0] o_exp_b
);

  localparam logic [1:0] c_G_ON  = (POLARITY != 0) ? LV_0 : LV_1;
  localparam logic [1:0] c_G_OFF = (POLARITY != 0) ? LV_1 : LV_0;

  logic w_on;
  logic w_off;

  assign w_on  = (i_g_drv == c_G_ON);
  assign w_off = (i_g_drv == c_G_OFF);

  // Value seen on terminal t, with o the terminal across the channel.
  function automatic logic [1:0] term_exp(
    input logic [1:0] t,
    input logic [1:0] o,
    input logic       on,
    input logic       off
  );
    logic [1:0] r;
    r = LV_X;
    if (t == LV_X) begin
      r = LV_X;
    end else if (t == LV_Z) begin
      if (off || (o == LV_Z))           r = LV_Z;
      else if (on && lv_is_driven(o))   r = o;
      else                              r = LV_X;
    end else begin
      if (off || (o == LV_Z) || (o == t)) r = t;
      else                                r = LV_X;
    end
    return r;
  endfunction

  always_comb begin
    o_exp_a = term_exp(i_a_drv, i_b_drv, w_on, w_off);
    o_exp_b = term_exp(i_b_drv, i_a_drv, w_on, w_off);
  end

endmodule : fet_expect
`default_nettype wire

// File: rtl/fet_response_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fet_response_checker : compares observed g/a/b nets of one FET against the
//                        expected switch-level result and counts errors. Rev 1.0
// ---------------------------------------------------------------------------
module fet_response_checker
  import fet_check_pkg::*;
#(
  parameter int POLARITY = 0,
  parameter int SETTLE   = 1,
  parameter int NVEC     = 16,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  input  logic [1:0]       g_drv,
  input  logic [1:0]       a_drv,
  input  logic [1:0]       b_drv,
  input  logic             g_obs,
  input  logic             a_obs,
  input  logic             b_obs,
  output logic             busy,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [4:0]       vec_count,
  output logic [4:0]       first_fail,
  output logic             overrun,
  output logic             done
);

  localparam logic [3:0]       c_CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] c_ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] c_ERR_ONE  = ERR_W'(1);
  localparam logic [4:0]       c_NO_FAIL  = 5'h1F;

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_cnt;
  logic [1:0]       r_g;
  logic [1:0]       r_a;
  logic [1:0]       r_b;
  logic [ERR_W-1:0] r_err;
  logic [4:0]       r_vec;
  logic [4:0]       r_first;
  logic             r_overrun;
  logic             r_done;

  logic [1:0]       w_exp_a;
  logic [1:0]       w_exp_b;
  logic [1:0]       w_obs_g;
  logic [1:0]       w_obs_a;
  logic [1:0]       w_obs_b;
  logic             w_check;
  logic             w_mis;
  logic [4:0]       w_vec_inc;

  fet_expect #(
    .POLARITY (POLARITY)
  ) u_expect (
    .i_g_drv (r_g),
    .i_a_drv (r_a),
    .i_b_drv (r_b),
    .o_exp_a (w_exp_a),
    .o_exp_b (w_exp_b)
  );

  assign w_obs_g   = lv_encode(g_obs);
  assign w_obs_a   = lv_encode(a_obs);
  assign w_obs_b   = lv_encode(b_obs);
  assign w_check   = (r_state == ST_CHECK);
  assign w_mis     = w_check &&
                     ((w_obs_g != r_g) || (w_obs_a != w_exp_a) || (w_obs_b != w_exp_b));
  assign w_vec_inc = r_vec + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // A strobe in SETTLE restarts the wait; a strobe in CHECK chains straight
  // into the next SETTLE once the current comparison retires.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (vec_valid) w_next = ST_SETTLE;
      ST_SETTLE: if (!vec_valid && (r_cnt == 4'd0)) w_next = ST_CHECK;
      ST_CHECK:  w_next = vec_valid ? ST_SETTLE : ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_g       <= LV_X;
      r_a       <= LV_X;
      r_b       <= LV_X;
      r_err     <= '0;
      r_vec     <= 5'd0;
      r_first   <= c_NO_FAIL;
      r_overrun <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (vec_valid) begin
        r_g   <= g_drv;
        r_a   <= a_drv;
        r_b   <= b_drv;
        r_cnt <= c_CNT_LOAD;
      end else if ((r_state == ST_SETTLE) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (vec_valid && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      if (w_check) begin
        r_vec <= w_vec_inc;
        if ({27'd0, w_vec_inc} == 32'(NVEC)) r_done <= 1'b1;
        if (w_mis) begin
          if (r_err != c_ERR_MAX)    r_err   <= r_err + c_ERR_ONE;
          if (r_first == c_NO_FAIL)  r_first <= r_vec;
        end
      end
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign mismatch   = w_mis;
  assign err_count  = r_err;
  assign vec_count  = r_vec;
  assign first_fail = r_first;
  assign overrun    = r_overrun;
  assign done       = r_done;

endmodule : fet_response_checker
`default_nettype wire
